muldiv_unit: RTL and testbench

- Iterative multiply/divide engine for the MIPS execute stage.
- Executes MULT, MULTU, DIV and DIVU in a fixed number of cycles.
- Presents a 64-bit result as Hi/Lo with a one-cycle Done strobe.
- Sits directly upstream of the HI and LO 32-bit registers: Hi/Lo feed their data inputs, Done drives their enables. Busy goes to hazard control to stall dependent MFHI/MFLO.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operation bus between the execute stage and the iterative multiply/divide engine.
// Carries the launch/abort controls, operands and the Hi/Lo result with its status.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Clear;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivByZero;

  modport master (
    output Start, Clear, Op, A, B,
    input  Busy, Done, Hi, Lo, DivByZero
  );

  modport slave (
    input  Start, Clear, Op, A, B,
    output Busy, Done, Hi, Lo, DivByZero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle on unsigned magnitudes,
// sign fix-up applied while the result is registered into Hi/Lo on entry to FINISH.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  muldiv_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam int         CW       = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_shift;
  logic               div_ge;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Datapath: acc holds {partial product, multiplier} for MULT and the dividend/quotient
  // shift register in its low half for DIV.
  always_comb begin
    signed_op = ~bus.Op[0];
    a_mag     = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {2'b00, b_q};
    rem_next  = div_ge ? (WIDTH+1)'(div_shift - {2'b00, b_q}) : (WIDTH+1)'(div_shift);
    quo_next  = {acc_q[WIDTH-2:0], div_ge};

    prod_fix  = (sign_a_q ^ sign_b_q) ? -mul_next : mul_next;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -quo_next : quo_next;
    // Remainder follows the dividend's sign, as MIPS requires.
    rem_fix   = sign_a_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Clear) begin
          is_div_d = bus.Op[1];
          sign_a_d = signed_op & bus.A[WIDTH-1];
          sign_b_d = signed_op & bus.B[WIDTH-1];
          b_d      = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          rem_d    = '0;
          cnt_d    = CW'(WIDTH);
          if (bus.Op[1] && (bus.B == '0)) begin
            // Divide by zero skips the iterations entirely.
            state_d = S_FINISH;
            hi_d    = bus.A;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.Clear) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
            rem_d = rem_next;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CW'(1)) begin
            state_d = S_FINISH;
            dbz_d   = 1'b0;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.Busy      = (state_q == S_RUN);
  assign bus.Done      = (state_q == S_FINISH) && !bus.Clear;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit, checked against a plain-arithmetic model
// of MULT/MULTU/DIV/DIVU including latency, divide-by-zero, Clear and async reset.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [64:0] last_exp;

  muldiv_unit_if #(.WIDTH(32)) mif ();

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} computed with 64-bit integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (op[1] && b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    case (op)
      2'b00: begin sp = sa * sb; return {1'b0, sp}; end
      2'b01: begin up = ua * ub; return {1'b0, up}; end
      2'b10: begin sq = sa / sb; sr = sa % sb; return {1'b0, sr[31:0], sq[31:0]}; end
      default: begin uq = ua / ub; ur = ua % ub; return {1'b0, ur[31:0], uq[31:0]}; end
    endcase
  endfunction

  // Launch one op; poke>0 re-asserts Start with junk operands in that cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input bit release_rst);
    logic [64:0] exp;
    int          cyc;
    int          busy_cnt;
    exp      = ref_model(op, a, b);
    busy_cnt = 0;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    mif.Start = 1'b1;
    mif.Op    = op;
    mif.A     = a;
    mif.B     = b;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mif.Done) break;
      if (mif.Busy) busy_cnt++;
      mif.Start = (cyc == poke);
      if (cyc == poke) begin
        mif.A  = ~a;
        mif.B  = a ^ b ^ 32'h5A5A_0001;
        mif.Op = ~op;
      end
    end
    mif.Start = 1'b0;
    check("done_cycle", 64'(cyc), exp[64] ? 64'd1 : 64'd33);
    check("busy_cycles", 64'(busy_cnt), exp[64] ? 64'd0 : 64'd32);
    check("hi", 64'(mif.Hi), 64'(exp[63:32]));
    check("lo", 64'(mif.Lo), 64'(exp[31:0]));
    check("div_by_zero", 64'(mif.DivByZero), 64'(exp[64]));
    $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d done_cycle=%0d",
             op, a, b, mif.Hi, mif.Lo, mif.DivByZero, cyc);
    @(negedge clk);
    check("done_pulse_width", 64'(mif.Done), 64'd0);
    check("hold_after_done", {mif.Hi, mif.Lo}, exp[63:0]);
    last_exp = exp;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          sel;
    bit          done_seen;
    n_checks  = 0;
    n_errors  = 0;
    last_exp  = '0;
    rst_n     = 1'b0;
    mif.Start = 1'b0;
    mif.Clear = 1'b0;
    mif.Op    = 2'b00;
    mif.A     = '0;
    mif.B     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(mif.Busy), 64'd0);
    check("reset_done", 64'(mif.Done), 64'd0);
    check("reset_hilo", {mif.Hi, mif.Lo}, 64'd0);
    check("reset_dbz", 64'(mif.DivByZero), 64'd0);
    rst_n = 1'b1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'b10, 32'h1234_5678, 32'h0, 0, 1'b0);
    do_op(2'b01, 32'd2, 32'd3, 0, 1'b0);
    do_op(2'b11, 32'hDEAD_BEEF, 32'd13, 5, 1'b0);

    // Clear at cycle 10 of a running op: back to IDLE, no Done, Hi/Lo untouched.
    @(negedge clk);
    mif.Start = 1'b1;
    mif.Op    = 2'b01;
    mif.A     = 32'h0000_1234;
    mif.B     = 32'h0000_5678;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mif.Start = 1'b0;
      if (c == 10) mif.Clear = 1'b1;
    end
    @(negedge clk);
    mif.Clear = 1'b0;
    check("clear_busy", 64'(mif.Busy), 64'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mif.Done || mif.Busy) done_seen = 1'b1;
    end
    check("clear_no_done", 64'(done_seen), 64'd0);
    check("clear_hilo_kept", {mif.Hi, mif.Lo}, last_exp[63:0]);
    $display("clear at cycle 10 -> hi=0x%08h lo=0x%08h", mif.Hi, mif.Lo);

    // Asynchronous reset between edges in cycle 12 of a running op.
    @(negedge clk);
    mif.Start = 1'b1;
    mif.Op    = 2'b10;
    mif.A     = 32'h7777_0000;
    mif.B     = 32'h0000_0003;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      mif.Start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(mif.Busy), 64'd0);
    check("async_rst_done", 64'(mif.Done), 64'd0);
    check("async_rst_hilo", {mif.Hi, mif.Lo}, 64'd0);
    check("async_rst_dbz", 64'(mif.DivByZero), 64'd0);
    $display("async reset mid-run -> busy=%0d hi=0x%08h lo=0x%08h", mif.Busy, mif.Hi, mif.Lo);
    do_op(2'b00, 32'h0001_0000, 32'hFFFF_0000, 0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h1;
        3:       begin rb = $urandom; ra = 32'h8000_0000; end
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, (i % 5 == 0) ? 7 : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
